// File: rtl/cdc_hs_receiver.sv
// Destination end of a 4-phase req/ack CDC handshake.
// req_async is synchronised into clk; the data word is captured once req_s
// is seen high (data is stable by protocol at that point) and offered on a
// valid/ready interface. ack is returned as a registered level.
module cdc_hs_receiver #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_async,
    input  logic [DATA_W-1:0] data_async,
    output logic              ack,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_cnt
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("cdc_hs_receiver: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_release;
    logic                   w_busy;
    logic                   r_ack;
    logic [DATA_W-1:0]      r_dout;
    logic                   r_dout_valid;
    logic [CNT_W-1:0]       r_xfer_cnt;

    // Request synchroniser chain; only its last stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_async};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> VALID -> ACK -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_s)                    w_state_nxt = ST_VALID;
            ST_VALID: if (r_dout_valid && dout_ready) w_state_nxt = ST_ACK;
            ST_ACK:   if (!w_req_s)                   w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: per-state strobes driving the registered outputs.
    // A req_s drop while in VALID is deliberately not looked at here.
    always_comb begin
        w_capture = (r_state == ST_IDLE)  && w_req_s;
        w_accept  = (r_state == ST_VALID) && r_dout_valid && dout_ready;
        w_release = (r_state == ST_ACK)   && !w_req_s;
        w_busy    = (r_state != ST_IDLE);
    end

    // Registered outputs: data capture, valid flag, ack level, transfer count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ack        <= 1'b0;
            r_xfer_cnt   <= '0;
        end else begin
            if (w_capture) begin
                r_dout       <= data_async;
                r_dout_valid <= 1'b1;
            end
            if (w_accept) begin
                r_dout_valid <= 1'b0;
                r_ack        <= 1'b1;
                r_xfer_cnt   <= r_xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_release) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign ack        = r_ack;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = w_busy;
    assign xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_cdc_hs_receiver.sv
// Directed bench for cdc_hs_receiver. A second instance with a 4-bit counter
// shares all inputs and is used to check counter wrap.
module tb_cdc_hs_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_async;
    logic [7:0]  data_async;
    logic        ack;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic [15:0] xfer_cnt;

    logic        ack4;
    logic [7:0]  dout4;
    logic        dout_valid4;
    logic        busy4;
    logic [3:0]  xfer_cnt4;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    cdc_hs_receiver #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .req_async(req_async), .data_async(data_async),
        .ack(ack), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .xfer_cnt(xfer_cnt)
    );

    cdc_hs_receiver #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_async(req_async), .data_async(data_async),
        .ack(ack4), .dout(dout4), .dout_valid(dout_valid4), .dout_ready(dout_ready),
        .busy(busy4), .xfer_cnt(xfer_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Full handshake with dout_ready high; bounded waits on ack.
    task automatic do_xfer(input logic [7:0] d);
        int n;
        data_async = d;
        req_async  = 1'b1;
        n = 0;
        while (!ack && n < 50) begin tick(); n++; end
        check("xfer_ack_rise", 32'(ack), 32'd1);
        req_async = 1'b0;
        n = 0;
        while (ack && n < 50) begin tick(); n++; end
        check("xfer_ack_fall", 32'(ack), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] exp_d;
        int n;
        int sent;
        int got;
        int phase;

        rst        = 1'b1;
        req_async  = 1'b0;
        data_async = 8'h00;
        dout_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_ack",   32'(ack),        32'd0);
        check("rst_dout",  32'(dout),       32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_cnt",   32'(xfer_cnt),   32'd0);

        // 1. Single transfer, exact latency; ready high while idle is ignored
        dout_ready = 1'b1;
        data_async = 8'hA5;
        req_async  = 1'b1;
        tick();
        check("t1_valid_e0", 32'(dout_valid), 32'd0);
        tick();
        check("t1_valid_e1", 32'(dout_valid), 32'd0);
        check("t1_cnt_idle", 32'(xfer_cnt),   32'd0);
        tick();
        check("t1_valid_e2", 32'(dout_valid), 32'd1);
        check("t1_dout",     32'(dout),       32'hA5);
        check("t1_busy",     32'(busy),       32'd1);
        check("t1_ack_pre",  32'(ack),        32'd0);
        tick();
        check("t1_ack",      32'(ack),        32'd1);
        check("t1_valid_lo", 32'(dout_valid), 32'd0);
        check("t1_cnt",      32'(xfer_cnt),   32'd1);
        req_async = 1'b0;
        tick();
        tick();
        check("t1_ack_hold", 32'(ack),        32'd1);
        tick();
        check("t1_ack_fall", 32'(ack),        32'd0);
        check("t1_busy_lo",  32'(busy),       32'd0);
        check("t1_cnt_end",  32'(xfer_cnt),   32'd1);

        // 2+3. Backpressure for 10 cycles with data churn during VALID
        dout_ready = 1'b0;
        data_async = 8'hA5;
        req_async  = 1'b1;
        n = 0;
        while (!dout_valid && n < 20) begin tick(); n++; end
        check("t2_valid_to", 32'(dout_valid), 32'd1);
        data_async = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_valid_hold", 32'(dout_valid), 32'd1);
            check("t2_dout_hold",  32'(dout),       32'hA5);
            check("t2_ack_lo",     32'(ack),        32'd0);
        end
        dout_ready = 1'b1;
        tick();
        check("t2_ack",      32'(ack),        32'd1);
        check("t2_dout_ack", 32'(dout),       32'hA5);
        req_async = 1'b0;
        n = 0;
        while (ack && n < 20) begin tick(); n++; end
        check("t2_ack_fall", 32'(ack),        32'd0);
        check("t2_cnt",      32'(xfer_cnt),   32'd2);

        // req drops while in VALID: word still delivered, ack still asserts
        dout_ready = 1'b0;
        data_async = 8'h69;
        req_async  = 1'b1;
        n = 0;
        while (!dout_valid && n < 20) begin tick(); n++; end
        check("tv_valid_to", 32'(dout_valid), 32'd1);
        req_async = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("tv_valid_hold", 32'(dout_valid), 32'd1);
        check("tv_dout",       32'(dout),       32'h69);
        dout_ready = 1'b1;
        tick();
        check("tv_ack",        32'(ack),        32'd1);
        check("tv_cnt",        32'(xfer_cnt),   32'd3);
        tick();
        check("tv_ack_fall",   32'(ack),        32'd0);

        // 4. 300 back-to-back transfers, random data and ready gaps
        do_reset();
        sent  = 0;
        got   = 0;
        phase = 0;
        n     = 0;
        while (!(sent == 300 && phase == 0 && got == 300) && n < 30000) begin
            dout_ready = 1'($urandom_range(0, 1));
            if (dout_valid && dout_ready) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("t4_data", 32'(dout), 32'(exp_d));
                got++;
            end
            case (phase)
                0: if (sent < 300) begin
                       data_async = 8'($urandom);
                       exp_q.push_back(data_async);
                       req_async = 1'b1;
                       sent++;
                       phase = 1;
                   end
                1: if (ack) begin
                       req_async = 1'b0;
                       phase = 2;
                   end
                default: if (!ack) phase = 0;
            endcase
            tick();
            n++;
        end
        check("t4_done",  32'(got),           32'd300);
        check("t4_qempty", 32'(exp_q.size()), 32'd0);
        check("t4_cnt",   32'(xfer_cnt),      32'd300);
        check("t4_cnt4",  32'(xfer_cnt4),     32'd12);

        // 5. Reset while in ACK, then a normal capture
        dout_ready = 1'b1;
        data_async = 8'hC3;
        req_async  = 1'b1;
        n = 0;
        while (!ack && n < 20) begin tick(); n++; end
        check("t5_ack_to", 32'(ack), 32'd1);
        rst        = 1'b1;
        data_async = 8'h5A;
        tick();
        rst = 1'b0;
        check("t5_ack",   32'(ack),        32'd0);
        check("t5_valid", 32'(dout_valid), 32'd0);
        check("t5_busy",  32'(busy),       32'd0);
        check("t5_cnt",   32'(xfer_cnt),   32'd0);
        tick();
        tick();
        check("t5_valid_e1", 32'(dout_valid), 32'd0);
        tick();
        check("t5_valid_e2", 32'(dout_valid), 32'd1);
        check("t5_dout",     32'(dout),       32'h5A);
        req_async = 1'b0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        check("t5_idle", 32'(busy),     32'd0);
        check("t5_cnt1", 32'(xfer_cnt), 32'd1);

        // 6. Counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) do_xfer(8'(i));
        check("t6_cnt4", 32'(xfer_cnt4), 32'd1);
        check("t6_cnt",  32'(xfer_cnt),  32'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
